// File: rtl/aes_pkg.sv
// Shared constants for the AES round controller: block width, key_size codes,
// round counts and FSM state encoding.
package aes_pkg;

    localparam int unsigned BlockW = 128;

    // key_size encodings
    localparam logic [1:0] KeySize128  = 2'b00;
    localparam logic [1:0] KeySize192  = 2'b01;
    localparam logic [1:0] KeySize256  = 2'b10;
    localparam logic [1:0] KeySizeRsvd = 2'b11;

    // Number of rounds (Nr) per key size
    localparam logic [3:0] Nr128 = 4'd10;
    localparam logic [3:0] Nr192 = 4'd12;
    localparam logic [3:0] Nr256 = 4'd14;

    // FSM state encoding
    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAddKey = 2'd1;
    localparam logic [1:0] StRound  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    // Round count for a (non-reserved) key_size code
    function automatic logic [3:0] nr_of(input logic [1:0] key_size);
        logic [3:0] nr;
        case (key_size)
            KeySize192: nr = Nr192;
            KeySize256: nr = Nr256;
            default:    nr = Nr128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// AES encryption round sequencer. Drives an external combinational round
// datapath and key schedule: one initial AddRoundKey, then Nr rounds, then a
// one-cycle done pulse. Optional feature macro AES_ROUND_CTRL_ABORT_EN adds an
// abort input that drops the block in flight.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        key_size,
    input  logic [0:BlockW-1] msg,
`ifdef AES_ROUND_CTRL_ABORT_EN
    input  logic              abort,
`endif
    output logic [3:0]        rk_idx,
    input  logic [0:BlockW-1] rk,
    output logic [0:BlockW-1] rnd_in,
    output logic              rnd_last,
    input  logic [0:BlockW-1] rnd_out,
    output logic              busy,
    output logic              done,
    output logic [0:BlockW-1] result,
    output logic              err
);

    logic [1:0]        fsm_q, fsm_d;
    logic [0:BlockW-1] blk_q, blk_d;
    logic [0:BlockW-1] result_q, result_d;
    logic [3:0]        nr_q, nr_d;
    logic [3:0]        rk_idx_q, rk_idx_d;
    logic              err_q, err_d;
    logic              abort_req;

`ifdef AES_ROUND_CTRL_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state: sequencing of the block state, round index and result
    always_comb begin
        fsm_d    = fsm_q;
        blk_d    = blk_q;
        result_d = result_q;
        nr_d     = nr_q;
        rk_idx_d = rk_idx_q;
        err_d    = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (start) begin
                    if (key_size == KeySizeRsvd) begin
                        err_d = 1'b1;
                    end else begin
                        blk_d    = msg;
                        nr_d     = nr_of(key_size);
                        rk_idx_d = 4'd0;
                        fsm_d    = StAddKey;
                    end
                end
            end
            StAddKey: begin
                if (abort_req) begin
                    fsm_d = StIdle;
                end else begin
                    blk_d    = blk_q ^ rk;
                    rk_idx_d = 4'd1;
                    fsm_d    = StRound;
                end
            end
            StRound: begin
                if (abort_req) begin
                    fsm_d = StIdle;
                end else begin
                    blk_d = rnd_out;
                    if (rk_idx_q < nr_q) begin
                        rk_idx_d = rk_idx_q + 4'd1;
                    end else begin
                        result_d = rnd_out;
                        fsm_d    = StDone;
                    end
                end
            end
            StDone: begin
                rk_idx_d = 4'd0;
                fsm_d    = StIdle;
            end
            default: fsm_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            fsm_q    <= StIdle;
            blk_q    <= '0;
            result_q <= '0;
            nr_q     <= Nr128;
            rk_idx_q <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            blk_q    <= blk_d;
            result_q <= result_d;
            nr_q     <= nr_d;
            rk_idx_q <= rk_idx_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy     = (fsm_q == StAddKey) || (fsm_q == StRound);
        done     = (fsm_q == StDone);
        rnd_last = (fsm_q == StRound) && (rk_idx_q == nr_q);
        rnd_in   = blk_q;
        rk_idx   = rk_idx_q;
        result   = result_q;
        err      = err_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: emulates the external round datapath and key
// schedule with a full AES model, and compares every cycle against a
// block-level model driven by FIPS-197 vectors and random traffic.
module tb_aes_round_ctrl;

    localparam logic [0:127] GoldMsg = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:255] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617,
                                     64'h0};
    localparam logic [0:255] K256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [0:127] R128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] R192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] R256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         sclk, rst, start;
    logic [1:0]   key_size;
    logic [0:127] msg, rk, rnd_in, rnd_out, result;
    logic [3:0]   rk_idx;
    logic         rnd_last, busy, done, err;
`ifdef AES_ROUND_CTRL_ABORT_EN
    logic         abort;
`endif
    logic [0:255] stim_key;

    int n_cmp = 0;
    int n_err = 0;

    aes_round_ctrl dut (
        .sclk     (sclk),
        .rst      (rst),
        .start    (start),
        .key_size (key_size),
        .msg      (msg),
`ifdef AES_ROUND_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .rk_idx   (rk_idx),
        .rk       (rk),
        .rnd_in   (rnd_in),
        .rnd_last (rnd_last),
        .rnd_out  (rnd_out),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .err      (err)
    );

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- AES reference ----------------
    logic [7:0] sbox [0:255];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    // All 15 round keys, key r at bits [128*r +: 128]
    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
        logic [31:0]   w [0:59];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [0:1919] ks;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        rcon = 8'h01;
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return ks;
    endfunction

    function automatic logic [0:127] aes_round(input logic [0:127] s, input logic [0:127] k,
                                               input logic last);
        logic [7:0]   b [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [0:127] o;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[8*i +: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = t[i] ^ k[8*i +: 8];
        return o;
    endfunction

    // ---------------- block-level model ----------------
    // m_age: edges since the accepting edge (0 = idle); busy for 1..Nr+1, done at Nr+2.
    int            m_age = 0;
    int            m_nr = 10;
    logic          m_err = 1'b0;
    logic [0:127]  m_state = '0;
    logic [0:127]  m_result = '0;
    logic [0:1919] m_rks = '0;
    logic [0:127]  m_traj [0:15];

    initial forever begin
        @(posedge sclk);
        m_err = 1'b0;
        if (rst) begin
            m_age = 0;
            m_state = '0;
            m_result = '0;
        end else if (m_age == 0) begin
            if (start && key_size == 2'b11) begin
                m_err = 1'b1;
            end else if (start) begin
                m_nr  = 10 + 2 * int'(key_size);
                m_rks = expand(stim_key, 4 + 2 * int'(key_size));
                m_traj[0] = msg;
                m_traj[1] = msg ^ m_rks[0 +: 128];
                for (int r = 1; r <= m_nr; r++)
                    m_traj[r+1] = aes_round(m_traj[r], m_rks[128*r +: 128], r == m_nr);
                m_state = msg;
                m_age = 1;
            end
        end else if (m_age == m_nr + 2) begin
            m_age = 0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        end else if (abort) begin
            m_age = 0;
`endif
        end else begin
            m_state = m_traj[m_age];
            m_age++;
            if (m_age == m_nr + 2) m_result = m_state;
        end
    end

    // External key schedule and round datapath
    initial begin
        rk = '0;
        rnd_out = '0;
        forever begin
            @(posedge sclk);
            #1;
            rk = (rk_idx <= 4'd14) ? m_rks[128*rk_idx +: 128] : '0;
            rnd_out = aes_round(rnd_in, rk, rnd_last);
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(posedge sclk);
        #2;
        check("busy", 128'(busy), 128'((m_age >= 1) && (m_age <= m_nr + 1)));
        check("done", 128'(done), 128'(m_age == m_nr + 2));
        check("rnd_last", 128'(rnd_last), 128'(m_age == m_nr + 1));
        check("err", 128'(err), 128'(m_err));
        check("rnd_in", rnd_in, m_state);
        check("result", result, m_result);
        if (m_age >= 1 && m_age <= m_nr + 1) check("rk_idx", 128'(rk_idx), 128'(m_age - 1));
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, 128'({busy, done, err, rnd_last, rk_idx}), '0);
        check({tag, "_rnd_in"}, rnd_in, '0);
        check({tag, "_result"}, result, '0);
    endtask

    // Golden block; start_edge injects a start pulse mid-run, rst_edge resets mid-run.
    task automatic run_golden(input string tag, input logic [1:0] ks, input logic [0:255] key,
                              input logic [0:127] want, input int want_edge,
                              input int start_edge, input int rst_edge);
        int e, done_edge, n_done, n_busy, n_last;
        logic [3:0] last_idx;
        e = 0; done_edge = 0; n_done = 0; n_busy = 0; n_last = 0; last_idx = 4'd0;
        start = 1'b1; key_size = ks; msg = GoldMsg; stim_key = key;
        for (int c = 0; c < 40; c++) begin
            @(posedge sclk);
            #3;
            e++;
            start = (e + 1 == start_edge);
            key_size = 2'($urandom);
            msg = {$urandom, $urandom, $urandom, $urandom};
            stim_key = {8{$urandom}};
            if (busy) n_busy++;
            if (rnd_last) begin n_last++; last_idx = rk_idx; end
            if (done) begin
                n_done++;
                if (done_edge == 0) done_edge = e;
            end
            if (rst_edge != 0 && e == rst_edge) begin
                rst = 1'b1;
                #1;
                check_reset_outputs({tag, "_async_rst"});
            end
            if (rst_edge != 0 && e == rst_edge + 1) begin
                rst = 1'b0;
                break;
            end
            if (rst_edge == 0 && e >= want_edge + 1) break;
        end
        start = 1'b0;
        if (rst_edge == 0) begin
            check({tag, "_done_edge"}, 128'(done_edge), 128'(want_edge));
            check({tag, "_done_count"}, 128'(n_done), 128'(1));
            check({tag, "_busy_cycles"}, 128'(n_busy), 128'(want_edge - 1));
            check({tag, "_last_count"}, 128'(n_last), 128'(1));
            check({tag, "_last_idx"}, 128'(last_idx), 128'(10 + 2 * int'(ks)));
            check({tag, "_result"}, result, want);
        end else begin
            check({tag, "_no_done"}, 128'(n_done), 128'(0));
        end
    endtask

    initial begin
        logic [7:0] inv;
        rst = 1'b1; start = 1'b0; key_size = 2'b00; msg = '0; stim_key = '0;
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
                      {inv[3:0], inv[7:4]} ^ 8'h63;
        end

        repeat (3) @(posedge sclk);
        #3;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge sclk);
        #3;

        run_golden("aes128", 2'b00, K128, R128, 12, 5, 0);
        run_golden("aes192", 2'b01, K192, R192, 14, 0, 0);
        run_golden("aes256", 2'b10, K256, R256, 16, 0, 0);

        // Reserved key size: one-cycle err, nothing else moves
        start = 1'b1; key_size = 2'b11; msg = {4{$urandom}};
        @(posedge sclk);
        #3;
        start = 1'b0;
        check("rsvd_err_pulse", 128'(err), 128'(1));
        check("rsvd_busy", 128'(busy), 128'(0));
        @(posedge sclk);
        #3;
        check("rsvd_err_clear", 128'(err), 128'(0));
        check("rsvd_no_done", 128'(done), 128'(0));
        check("rsvd_result_kept", result, R256);

        run_golden("aes256_rst", 2'b10, K256, R256, 16, 0, 6);
        run_golden("aes128_after_rst", 2'b00, K128, R128, 12, 0, 0);

        // Random traffic with stray starts, input churn, occasional resets
        for (int n = 0; n < 40; n++) begin
            start = 1'b1;
            key_size = 2'($urandom_range(0, 3));
            msg = {$urandom, $urandom, $urandom, $urandom};
            stim_key = {8{$urandom}};
`ifdef AES_ROUND_CTRL_ABORT_EN
            abort = 1'($urandom_range(0, 1));
`endif
            @(posedge sclk);
            #3;
            for (int c = 0; c < 40 && m_age != 0; c++) begin
                start = ($urandom_range(0, 3) == 0);
                key_size = 2'($urandom);
                msg = {$urandom, $urandom, $urandom, $urandom};
                stim_key = {8{$urandom}};
                rst = ($urandom_range(0, 59) == 0);
`ifdef AES_ROUND_CTRL_ABORT_EN
                abort = ($urandom_range(0, 19) == 0);
`endif
                @(posedge sclk);
                #3;
            end
            check("random_block_finished", 128'(m_age), '0);
            start = 1'b0;
            rst = 1'b0;
`ifdef AES_ROUND_CTRL_ABORT_EN
            abort = 1'b0;
`endif
            repeat ($urandom_range(0, 3)) @(posedge sclk);
            #3;
        end

        repeat (2) @(posedge sclk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have ports: sclk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  request to encrypt one block, sampled only in IDLE.
REQ-004 SHALL have ports: key_size  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=reserved.
REQ-005 SHALL have ports: msg  in  128 [0:127]  plaintext block, sampled with start.
REQ-006 SHALL have ports: rk_idx  out  4  round-key index to key schedule; rk valid combinationally for it.
REQ-007 SHALL have ports: rk  in  128 [0:127]  round key w[128*rk_idx +: 128] from key schedule.
REQ-008 SHALL have ports: rnd_in  out  128 [0:127]  current state to combinational round datapath.
REQ-009 SHALL have ports: rnd_last  out  1  high during the final round (datapath skips MixColumns).
REQ-010 SHALL have ports: rnd_out  in  128 [0:127]  round datapath result for rnd_in, rk, rnd_last.
REQ-011 SHALL have ports: busy  out  1; done  out  1; result  out  128 [0:127]; err  out  1.

Function
REQ-012 SHALL implement FSM IDLE -> ADDKEY -> ROUND -> DONE -> IDLE.
REQ-013 IDLE: start=1 with key_size!=11 SHALL latch msg into state reg, latch Nr, set rk_idx=0, go ADDKEY.
REQ-014 IDLE: start=1 with key_size=11 SHALL pulse err for one cycle, stay IDLE, leave result unchanged.
REQ-015 ADDKEY: state <= state XOR rk (rk_idx=0); rk_idx <= 1; go ROUND.
REQ-016 ROUND: state <= rnd_out; rnd_last = (rk_idx==Nr); if rk_idx<Nr then rk_idx++ else result <= rnd_out, go DONE.
REQ-017 DONE: done=1 for exactly one cycle, busy=0, go IDLE; done asserts Nr+2 edges after start-accept edge (12/14/16).
REQ-018 busy SHALL be 1 in ADDKEY and ROUND only; rnd_in SHALL equal state reg at all times.
REQ-019 start while busy or in DONE SHALL be ignored, no queuing, no err.
REQ-020 key_size and msg changes after accept SHALL NOT affect the block in flight.
REQ-021 result SHALL hold its value from DONE until the next completed block.
REQ-022 rk_idx SHALL never exceed latched Nr; rnd_last SHALL be 0 outside ROUND.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, busy=0, done=0, err=0, rk_idx=0, rnd_last=0, state reg=0, result=0.
REQ-024 rst asserted mid-operation SHALL abandon the block without done; first start after release is accepted normally.

Configuration
REQ-025 Macro AES_ROUND_CTRL_ABORT_EN defined: input port abort (1 bit) SHALL exist; abort=1 in ADDKEY/ROUND returns to IDLE on next edge, no done, result unchanged, err=0; abort ignored in IDLE/DONE; abort and start in the same IDLE cycle -> start wins.
REQ-026 Macro undefined: abort port absent; every accepted block runs to DONE.

Structure
REQ-027 Shared package aes_pkg SHALL hold key_size codes, Nr constants (10/12/14), FSM state encoding and the 128-bit block width.
REQ-028 SHALL be a single module with no sub-module; round datapath and key schedule remain external.

Verification
REQ-029 AES-128, msg=00112233445566778899aabbccddeeff, key=000102..0f, golden round model -> result=69c4e0d86a7b0430d8cdb78070b4c55a, done at edge 12.
REQ-030 AES-192, same msg, key=000102..17 -> result=dda97ca4864cdfe06eaf70a0ec0d7191, done at edge 14, rk_idx sequence 0..12.
REQ-031 AES-256, same msg, key=000102..1f -> result=8ea2b7ca516745bfeafc49904b496089, done at edge 16, rnd_last only with rk_idx=14.
REQ-032 key_size=11 with start -> err one-cycle pulse, busy stays 0, no done, result unchanged.
REQ-033 start pulsed at edge 5 of a busy AES-128 run -> ignored, exactly one done at edge 12, result correct.
REQ-034 rst at edge 6 of AES-256 run -> outputs at reset values, no done; new AES-128 start -> correct result at edge 12.
